// File: rtl/conv_mem_host.sv
// Host-side memory responder for the convolution accelerator: image store, five layer
// banks, run sequencing (load -> arm -> run -> done) and a post-run readback port.
module conv_mem_host #(
  parameter int DW        = 20,
  parameter int AW        = 12,
  parameter int IMG_DEPTH = 4096,
  parameter int L0_DEPTH  = 4096,
  parameter int L1_DEPTH  = 1024,
  parameter int L2_DEPTH  = 2048,
  parameter int TIMEOUT   = 300000
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld_valid,
  input  logic [DW-1:0] ld_data,
  output logic          ld_ready,
  input  logic          start,
  output logic          ready,
  input  logic          busy,
  input  logic [AW-1:0] iaddr,
  output logic [DW-1:0] idata,
  input  logic          crd,
  input  logic [AW-1:0] caddr_rd,
  output logic [DW-1:0] cdata_rd,
  input  logic          cwr,
  input  logic [AW-1:0] caddr_wr,
  input  logic [DW-1:0] cdata_wr,
  input  logic [2:0]    csel,
  output logic          done,
  output logic          timeout,
  output logic          err,
  output logic [13:0]   wr_count,
  input  logic [2:0]    rb_sel,
  input  logic [AW-1:0] rb_addr,
  output logic [DW-1:0] rb_data
);
  localparam int IMG_AW = $clog2(IMG_DEPTH);
  localparam int L0_AW  = $clog2(L0_DEPTH);
  localparam int L1_AW  = $clog2(L1_DEPTH);
  localparam int L2_AW  = $clog2(L2_DEPTH);
  localparam int CW     = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_LOADED, S_ARM, S_RUN, S_DONE} state_t;

  logic [DW-1:0] img_mem  [IMG_DEPTH];
  logic [DW-1:0] l0k0_mem [L0_DEPTH];
  logic [DW-1:0] l0k1_mem [L0_DEPTH];
  logic [DW-1:0] l1k0_mem [L1_DEPTH];
  logic [DW-1:0] l1k1_mem [L1_DEPTH];
  logic [DW-1:0] l2_mem   [L2_DEPTH];

  state_t            state_q, state_d;
  logic [IMG_AW-1:0] ld_cnt_q, ld_cnt_d;
  logic [CW-1:0]     run_cnt_q, run_cnt_d;
  logic              timeout_q, timeout_d;
  logic              err_q, err_d;
  logic [13:0]       wr_cnt_q, wr_cnt_d;
  logic              img_we;
  logic [IMG_AW-1:0] img_waddr;
  logic              wr_ok;

  function automatic logic in_range(input logic [2:0] sel, input logic [AW-1:0] addr);
    logic [31:0] a;
    a = 32'(addr);
    case (sel)
      3'b001, 3'b010: in_range = a < 32'(L0_DEPTH);
      3'b011, 3'b100: in_range = a < 32'(L1_DEPTH);
      3'b101:         in_range = a < 32'(L2_DEPTH);
      default:        in_range = 1'b0;
    endcase
  endfunction

  // Illegal selects and out-of-range addresses read as zero.
  function automatic logic [DW-1:0] bank_rd(input logic [2:0] sel, input logic [AW-1:0] addr);
    bank_rd = '0;
    if (in_range(sel, addr)) begin
      case (sel)
        3'b001:  bank_rd = l0k0_mem[addr[L0_AW-1:0]];
        3'b010:  bank_rd = l0k1_mem[addr[L0_AW-1:0]];
        3'b011:  bank_rd = l1k0_mem[addr[L1_AW-1:0]];
        3'b100:  bank_rd = l1k1_mem[addr[L1_AW-1:0]];
        3'b101:  bank_rd = l2_mem[addr[L2_AW-1:0]];
        default: bank_rd = '0;
      endcase
    end
  endfunction

  assign idata    = img_mem[iaddr[IMG_AW-1:0]];
  assign cdata_rd = crd ? bank_rd(csel, caddr_rd) : '0;
  assign rb_data  = bank_rd(rb_sel, rb_addr);
  assign timeout  = timeout_q;
  assign err      = err_q;
  assign wr_count = wr_cnt_q;
  assign wr_ok    = cwr && in_range(csel, caddr_wr) && (state_q == S_ARM || state_q == S_RUN);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_IDLE;
      ld_cnt_q  <= '0;
      run_cnt_q <= '0;
      timeout_q <= 1'b0;
      err_q     <= 1'b0;
      wr_cnt_q  <= '0;
    end else begin
      state_q   <= state_d;
      ld_cnt_q  <= ld_cnt_d;
      run_cnt_q <= run_cnt_d;
      timeout_q <= timeout_d;
      err_q     <= err_d;
      wr_cnt_q  <= wr_cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ld_cnt_d  = ld_cnt_q;
    run_cnt_d = run_cnt_q;
    timeout_d = timeout_q;
    err_d     = err_q;
    wr_cnt_d  = wr_cnt_q;
    img_we    = 1'b0;
    img_waddr = ld_cnt_q;
    ld_ready  = 1'b0;
    ready     = 1'b0;
    done      = 1'b0;
    if ((crd && !in_range(csel, caddr_rd)) || (cwr && !wr_ok)) err_d = 1'b1;
    if (wr_ok && wr_cnt_q != 14'h3FFF) wr_cnt_d = wr_cnt_q + 1'b1;
    case (state_q)
      S_IDLE: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          img_we    = 1'b1;
          img_waddr = '0;
          ld_cnt_d  = IMG_AW'(1);
          state_d   = S_LOAD;
        end
      end
      S_LOAD: begin
        ld_ready = 1'b1;
        if (ld_valid) begin
          img_we   = 1'b1;
          ld_cnt_d = ld_cnt_q + 1'b1;
          if (ld_cnt_q == IMG_AW'(IMG_DEPTH - 1)) state_d = S_LOADED;
        end
      end
      S_LOADED, S_DONE: begin
        ld_ready = 1'b1;
        done     = (state_q == S_DONE);
        // start has priority over a new image beat; run status clears on entry to ARM.
        if (start) begin
          state_d   = S_ARM;
          err_d     = 1'b0;
          timeout_d = 1'b0;
          wr_cnt_d  = '0;
          run_cnt_d = '0;
        end else if (ld_valid) begin
          img_we    = 1'b1;
          img_waddr = '0;
          ld_cnt_d  = IMG_AW'(1);
          state_d   = S_LOAD;
        end
      end
      S_ARM: begin
        ready     = 1'b1;
        run_cnt_d = '0;
        if (busy) state_d = S_RUN;
      end
      S_RUN: begin
        run_cnt_d = run_cnt_q + 1'b1;
        if (!busy) begin
          state_d = S_DONE;
        end else if (run_cnt_q == CW'(TIMEOUT - 1)) begin
          state_d   = S_DONE;
          timeout_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Memories are never cleared; writes are suppressed only while reset is asserted.
  always_ff @(posedge clk) begin
    if (img_we && !reset) img_mem[img_waddr] <= ld_data;
    if (wr_ok && !reset) begin
      case (csel)
        3'b001:  l0k0_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'b010:  l0k1_mem[caddr_wr[L0_AW-1:0]] <= cdata_wr;
        3'b011:  l1k0_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'b100:  l1k1_mem[caddr_wr[L1_AW-1:0]] <= cdata_wr;
        3'b101:  l2_mem[caddr_wr[L2_AW-1:0]]   <= cdata_wr;
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_conv_mem_host.sv
// Directed bench for conv_mem_host: load, run handshake, layer access, timeout, reset.
module tb_conv_mem_host;
  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        ld_valid = 1'b0;
  logic [19:0] ld_data = '0;
  logic        ld_ready;
  logic        start = 1'b0;
  logic        ready;
  logic        busy = 1'b0;
  logic [11:0] iaddr = '0;
  logic [19:0] idata;
  logic        crd = 1'b0;
  logic [11:0] caddr_rd = '0;
  logic [19:0] cdata_rd;
  logic        cwr = 1'b0;
  logic [11:0] caddr_wr = '0;
  logic [19:0] cdata_wr = '0;
  logic [2:0]  csel = '0;
  logic        done;
  logic        timeout;
  logic        err;
  logic [13:0] wr_count;
  logic [2:0]  rb_sel = '0;
  logic [11:0] rb_addr = '0;
  logic [19:0] rb_data;

  int errors = 0;
  int checks = 0;

  conv_mem_host #(.TIMEOUT(100)) dut (
    .clk(clk), .reset(reset), .ld_valid(ld_valid), .ld_data(ld_data), .ld_ready(ld_ready),
    .start(start), .ready(ready), .busy(busy), .iaddr(iaddr), .idata(idata),
    .crd(crd), .caddr_rd(caddr_rd), .cdata_rd(cdata_rd), .cwr(cwr), .caddr_wr(caddr_wr),
    .cdata_wr(cdata_wr), .csel(csel), .done(done), .timeout(timeout), .err(err),
    .wr_count(wr_count), .rb_sel(rb_sel), .rb_addr(rb_addr), .rb_data(rb_data)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    tick; tick;
    reset = 1'b0;
    #1;
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL rst_ld_ready got=%0h exp=1", ld_ready); end
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL rst_ready got=%0h exp=0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL rst_done got=%0h exp=0", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL rst_timeout got=%0h exp=0", timeout); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rst_err got=%0h exp=0", err); end
    checks++; if (wr_count !== 14'd0) begin errors++; $display("FAIL rst_wr_count got=%0d exp=0", wr_count); end
    checks++; if (cdata_rd !== 20'h0) begin errors++; $display("FAIL rst_cdata_rd got=%0h exp=0", cdata_rd); end
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL idle_start_ignored ready got=%0h exp=0", ready); end
    csel = 3'b101; caddr_wr = 12'd7; cdata_wr = 20'h11111; cwr = 1'b1;
    tick;
    cwr = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL idle_write_err got=%0h exp=1", err); end
    rb_sel = 3'b101; rb_addr = 12'd7;
    #1;
    checks++; if (rb_data === 20'h11111) begin errors++; $display("FAIL idle_write_dropped got=%0h exp=not 11111", rb_data); end
  endtask

  task automatic test_load;
    int acc = 0;
    for (int i = 0; i < 4096; i++) begin
      ld_valid = 1'b1;
      ld_data  = 20'(i);
      #1;
      if (ld_valid && ld_ready) acc++;
      tick;
    end
    ld_valid = 1'b0;
    #1;
    checks++; if (acc != 4096) begin errors++; $display("FAIL load_accepts got=%0d exp=4096", acc); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL loaded_ld_ready got=%0h exp=1", ld_ready); end
    iaddr = 12'hFFF;
    #1;
    checks++; if (idata !== 20'h00FFF) begin errors++; $display("FAIL idata_fff got=%0h exp=00fff", idata); end
    iaddr = 12'd5;
    #1;
    checks++; if (idata !== 20'h00005) begin errors++; $display("FAIL idata_5 got=%0h exp=00005", idata); end
  endtask

  task automatic test_run_start;
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready got=%0h exp=1", ready); end
    checks++; if (ld_ready !== 1'b0) begin errors++; $display("FAIL arm_ld_ready got=%0h exp=0", ld_ready); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arm_err_clear got=%0h exp=0", err); end
    tick;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL arm_ready_hold got=%0h exp=1", ready); end
    busy = 1'b1;
    tick;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL run_ready_drop got=%0h exp=0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL run_done got=%0h exp=0", done); end
  endtask

  task automatic test_layer_rw;
    csel = 3'b011; caddr_wr = 12'h3FF; cdata_wr = 20'h12345; cwr = 1'b1;
    tick;
    cwr = 1'b0; crd = 1'b1; caddr_rd = 12'h3FF;
    #1;
    checks++; if (cdata_rd !== 20'h12345) begin errors++; $display("FAIL l1_read got=%0h exp=12345", cdata_rd); end
    checks++; if (wr_count !== 14'd1) begin errors++; $display("FAIL l1_wr_count got=%0d exp=1", wr_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL l1_err got=%0h exp=0", err); end
    crd = 1'b0;
    #1;
    checks++; if (cdata_rd !== 20'h0) begin errors++; $display("FAIL crd_low_zero got=%0h exp=0", cdata_rd); end
    csel = 3'b101; caddr_wr = 12'd7; cdata_wr = 20'hAAAAA; cwr = 1'b1;
    tick;
    cdata_wr = 20'h55555; crd = 1'b1; caddr_rd = 12'd7;
    #1;
    checks++; if (cdata_rd !== 20'hAAAAA) begin errors++; $display("FAIL rw_same_old got=%0h exp=aaaaa", cdata_rd); end
    tick;
    cwr = 1'b0;
    #1;
    checks++; if (cdata_rd !== 20'h55555) begin errors++; $display("FAIL rw_same_new got=%0h exp=55555", cdata_rd); end
    checks++; if (wr_count !== 14'd3) begin errors++; $display("FAIL rw_wr_count got=%0d exp=3", wr_count); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rw_err got=%0h exp=0", err); end
    crd = 1'b0;
    csel = 3'b011; caddr_wr = 12'h400; cdata_wr = 20'h0BEEF; cwr = 1'b1;
    tick;
    cwr = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL oor_write_err got=%0h exp=1", err); end
    checks++; if (wr_count !== 14'd3) begin errors++; $display("FAIL oor_wr_count got=%0d exp=3", wr_count); end
    rb_sel = 3'b011; rb_addr = 12'h3FF;
    #1;
    checks++; if (rb_data !== 20'h12345) begin errors++; $display("FAIL rb_l1k0 got=%0h exp=12345", rb_data); end
    rb_addr = 12'h400;
    #1;
    checks++; if (rb_data !== 20'h0) begin errors++; $display("FAIL rb_oor got=%0h exp=0", rb_data); end
  endtask

  task automatic test_run_end;
    busy = 1'b0;
    #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL done_early got=%0h exp=0", done); end
    tick;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_rise got=%0h exp=1", done); end
    tick;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL done_held got=%0h exp=1", done); end
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL done_timeout got=%0h exp=0", timeout); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL done_ld_ready got=%0h exp=1", ld_ready); end
  endtask

  task automatic test_integration;
    logic [2:0]  wsel [5];
    logic [11:0] wadr [5];
    logic [19:0] wdat [5];
    wsel = '{3'b001, 3'b010, 3'b100, 3'b101, 3'b001};
    wadr = '{12'hFFF, 12'h000, 12'h3FF, 12'h7FF, 12'h000};
    wdat = '{20'h10001, 20'h20002, 20'h40004, 20'h50005, 20'h1000F};
    start = 1'b1; ld_valid = 1'b1; ld_data = 20'h77777;
    tick;
    start = 1'b0; ld_valid = 1'b0; iaddr = 12'd0;
    #1;
    checks++; if (ready !== 1'b1) begin errors++; $display("FAIL start_wins ready got=%0h exp=1", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL arm_done_clear got=%0h exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arm2_err got=%0h exp=0", err); end
    checks++; if (wr_count !== 14'd0) begin errors++; $display("FAIL arm2_wr_count got=%0d exp=0", wr_count); end
    checks++; if (idata !== 20'h0) begin errors++; $display("FAIL start_wins_img0 got=%0h exp=0", idata); end
    busy = 1'b1;
    tick;
    for (int i = 0; i < 5; i++) begin
      csel = wsel[i]; caddr_wr = wadr[i]; cdata_wr = wdat[i]; cwr = 1'b1;
      tick;
    end
    cwr = 1'b0;
    #1;
    checks++; if (wr_count !== 14'd5) begin errors++; $display("FAIL int_wr_count got=%0d exp=5", wr_count); end
    for (int i = 1; i < 5; i++) begin
      rb_sel = wsel[i]; rb_addr = wadr[i];
      #1;
      checks++; if (rb_data !== wdat[i]) begin errors++; $display("FAIL rb_bank%0d got=%0h exp=%0h", i, rb_data, wdat[i]); end
    end
    rb_sel = 3'b001; rb_addr = 12'hFFF;
    #1;
    checks++; if (rb_data !== 20'h10001) begin errors++; $display("FAIL rb_l0k0_top got=%0h exp=10001", rb_data); end
    rb_sel = 3'b000; rb_addr = 12'd0;
    #1;
    checks++; if (rb_data !== 20'h0) begin errors++; $display("FAIL rb_sel0 got=%0h exp=0", rb_data); end
    rb_sel = 3'b101; rb_addr = 12'h800;
    #1;
    checks++; if (rb_data !== 20'h0) begin errors++; $display("FAIL rb_l2_oor got=%0h exp=0", rb_data); end
    rb_sel = 3'b111;
    tick;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL rb_no_err got=%0h exp=0", err); end
    crd = 1'b1; csel = 3'b101; caddr_rd = 12'h800;
    #1;
    checks++; if (cdata_rd !== 20'h0) begin errors++; $display("FAIL rd_oor_zero got=%0h exp=0", cdata_rd); end
    tick;
    crd = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rd_oor_err got=%0h exp=1", err); end
    busy = 1'b0;
    tick;
    #1;
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL int_done got=%0h exp=1", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL err_sticky got=%0h exp=1", err); end
  endtask

  task automatic test_timeout;
    int n = 0;
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL arm3_err got=%0h exp=0", err); end
    busy = 1'b1;
    tick;
    while (n < 200) begin
      if (n == 0) begin csel = 3'b110; caddr_wr = 12'd0; cwr = 1'b1; end
      tick;
      cwr = 1'b0;
      n++;
      #1;
      if (done === 1'b1) break;
    end
    checks++; if (n != 100) begin errors++; $display("FAIL timeout_cycles got=%0d exp=100", n); end
    checks++; if (timeout !== 1'b1) begin errors++; $display("FAIL timeout_flag got=%0h exp=1", timeout); end
    checks++; if (done !== 1'b1) begin errors++; $display("FAIL timeout_done got=%0h exp=1", done); end
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL csel110_err got=%0h exp=1", err); end
    checks++; if (wr_count !== 14'd0) begin errors++; $display("FAIL csel110_wr_count got=%0d exp=0", wr_count); end
    busy = 1'b0;
  endtask

  task automatic test_reset_mid_run;
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    checks++; if (timeout !== 1'b0) begin errors++; $display("FAIL arm4_timeout_clear got=%0h exp=0", timeout); end
    busy = 1'b1;
    tick;
    crd = 1'b1; csel = 3'b000; caddr_rd = 12'd0;
    #1;
    checks++; if (cdata_rd !== 20'h0) begin errors++; $display("FAIL rd_sel0_zero got=%0h exp=0", cdata_rd); end
    tick;
    crd = 1'b0;
    #1;
    checks++; if (err !== 1'b1) begin errors++; $display("FAIL rd_sel0_err got=%0h exp=1", err); end
    reset = 1'b1;
    tick;
    reset = 1'b0;
    busy = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL mid_rst_ready got=%0h exp=0", ready); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL mid_rst_done got=%0h exp=0", done); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL mid_rst_err got=%0h exp=0", err); end
    checks++; if (ld_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ld_ready got=%0h exp=1", ld_ready); end
    rb_sel = 3'b011; rb_addr = 12'h3FF; iaddr = 12'd5;
    #1;
    checks++; if (rb_data !== 20'h12345) begin errors++; $display("FAIL mem_kept_l1 got=%0h exp=12345", rb_data); end
    checks++; if (idata !== 20'h00005) begin errors++; $display("FAIL mem_kept_img got=%0h exp=00005", idata); end
    start = 1'b1;
    tick;
    start = 1'b0;
    #1;
    checks++; if (ready !== 1'b0) begin errors++; $display("FAIL start_needs_load got=%0h exp=0", ready); end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset;
    test_load;
    test_run_start;
    test_layer_rw;
    test_run_end;
    test_integration;
    test_timeout;
    test_reset_mid_run;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/conv_mem_host.md
# conv_mem_host

Host-side memory responder for the convolution accelerator. It owns the 64x64 input image store and the five layer result banks, and serves the accelerator's image-read port and layer read/write ports. It sequences a run: stream the image in, raise `ready`, track `busy` to completion, then flag `done`. A readback port lets the host dump any bank after the run.

## Interface
Parameters:
- `DW`, 20: data width (image pixels and layer data).
- `AW`, 12: address width of every port.
- `IMG_DEPTH`, 4096: image words.
- `L0_DEPTH`, 4096: depth of each layer-0 bank.
- `L1_DEPTH`, 1024: depth of each layer-1 bank.
- `L2_DEPTH`, 2048: depth of the layer-2 bank.
- `TIMEOUT`, 300000: maximum cycles in RUN before forced completion.

Ports:
- `clk` in 1: clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `ld_valid` in 1: image load beat valid.
- `ld_data` in DW: image pixel.
- `ld_ready` out 1: image beat accepted when `ld_valid && ld_ready`.
- `start` in 1: request a run.
- `ready` out 1: to accelerator, image available.
- `busy` in 1: from accelerator.
- `iaddr` in AW: image read address.
- `idata` out DW: image read data.
- `crd` in 1: layer read enable.
- `caddr_rd` in AW: layer read address.
- `cdata_rd` out DW: layer read data.
- `cwr` in 1: layer write enable.
- `caddr_wr` in AW: layer write address.
- `cdata_wr` in DW: layer write data.
- `csel` in 3: bank select.
- `done` out 1: run finished, held until next ARM or LOAD.
- `timeout` out 1: last run ended by TIMEOUT.
- `err` out 1: sticky illegal access, cleared on entry to ARM.
- `wr_count` out 14: layer writes accepted in the current or last run.
- `rb_sel` in 3: readback bank select, same encoding as `csel`.
- `rb_addr` in AW: readback address.
- `rb_data` out DW: readback data.

## Operation
- Bank map for `csel`/`rb_sel`:
  - 001 L0K0 (L0_DEPTH)
  - 010 L0K1 (L0_DEPTH)
  - 011 L1K0 (L1_DEPTH)
  - 100 L1K1 (L1_DEPTH)
  - 101 L2 (L2_DEPTH)
  - 000, 110 and 111 are illegal.
- Memories: asynchronous read, synchronous write. Contents are not cleared by `reset`.
- FSM states:
  - IDLE: `ld_ready`=1. An accepted beat writes image[0], sets ld_cnt=1 and goes to LOAD.
  - LOAD: `ld_ready`=1. Each accepted beat writes image[ld_cnt] and increments ld_cnt. The beat with ld_cnt==IMG_DEPTH-1 goes to LOADED.
  - LOADED: `ld_ready`=1. `start` goes to ARM. `ld_valid` restarts the load at address 0 (goes to LOAD). If both are high, `start` wins.
  - ARM: `ready`=1. Clears `err`, `timeout` and `wr_count`. Goes to RUN when `busy`==1 is sampled, and `ready` drops the same edge.
  - RUN: the cycle counter increments every cycle. Goes to DONE when `busy`==0 is sampled, or when the counter reaches TIMEOUT (which also sets `timeout`).
  - DONE: `done`=1 and `ld_ready`=1. Transitions are the same as LOADED.
- Image read: `idata` = image[`iaddr`] combinationally, in every state.
- Layer read: `cdata_rd` = bank[`csel`][`caddr_rd`] combinationally when `crd`=1, otherwise 0. An illegal `csel` or an address at or beyond the bank depth returns 0 and sets `err` at the next edge.
- Layer write: on the rising edge with `cwr`=1 in ARM or RUN, write `cdata_wr` to bank[`csel`][`caddr_wr`] and increment `wr_count`, which saturates at 16383.
  - A write with an illegal `csel`, an out-of-range address, or occurring outside ARM/RUN is dropped and sets `err`.
- Same bank, same address, `crd` and `cwr` in the same cycle: `cdata_rd` returns the old data, and the new data is visible the next cycle.
- Readback: `rb_data` = bank[`rb_sel`][`rb_addr`] combinationally. It returns 0 for an illegal select or an out-of-range address, never sets `err`, and is valid in any state.

## Timing
- Reset values:
  - state IDLE, ld_cnt 0, RUN counter 0.
  - `ld_ready` 1 (IDLE).
  - `ready` 0, `done` 0, `timeout` 0, `err` 0, `wr_count` 0.
  - `idata`, `cdata_rd` and `rb_data` follow the combinational read rules.
- Image load: one beat per cycle at full rate. The image is complete IMG_DEPTH accepted beats after the first.
- Run start: `start` sampled in LOADED/DONE gives `ready`=1 on the next cycle. `ready` stays high until the edge after `busy` is first sampled high.
- Run end: `busy` sampled low in RUN gives `done`=1 on the next cycle.
- Read latency 0 cycles (same-cycle combinational). Write latency 1 edge.
- `reset` mid-LOAD or mid-RUN: return to IDLE at that edge. Memory contents are kept, and a new load is required before `start`.
- `start` in IDLE or LOAD is ignored.

## Test plan
- Load image[i]=i for i=0..4095 with `ld_valid` held high. Expect 4096 accepts, state LOADED, `idata`=0x00FFF when `iaddr`=0xFFF, and `idata`=0x00005 when `iaddr`=5 in the same cycle.
- `start` pulse, then `busy`=1 two cycles after `ready` rises. Expect `ready` low after the first sampled `busy`. After `busy`=0, expect `done`=1 exactly one cycle later, held high.
- In RUN, write csel=011, addr 0x3FF, data 0x12345, then `crd` with the same address the next cycle. Expect `cdata_rd`=0x12345, `wr_count`=1, `err`=0. Then write csel=011 at addr 0x400: dropped, `err`=1, `wr_count` unchanged.
- Same-cycle read and write to L2 addr 7: old value 0xAAAAA is on `cdata_rd` that cycle, 0x55555 the next cycle. A write with csel=110 sets `err`.
- With TIMEOUT overridden to 100 and `busy` held high: expect DONE entered after 100 RUN cycles, `timeout`=1, `done`=1.
- Full integration with the accelerator on a known 64x64 image: `wr_count`=12288, and `rb_data` for banks 001 to 101 matches the golden files word-for-word. Assert `reset` mid-RUN: state returns to IDLE and `ready`, `done`, `err` all read 0 the next cycle.
